alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Multicycle, handshaked successor to the team's combinational 8-bit ALU. It is parametrised in WIDTH and adds rotate, arithmetic shift, full-width multiply (low/high) and unsigned divide/remainder. The multiply and divide ops are computed iteratively, one bit per clock. It sits between the operand-fetch stage (valid/ready producer) and the writeback stage (valid/ready consumer). Result and flags are registered and held until the consumer accepts them.

Parameters:
WIDTH, 8, operand/result width in bits; legal range is 4 to 32.

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands/op_code are valid
in_ready  out  1  block can accept an operation this cycle
A  in  WIDTH  first operand
B  in  WIDTH  second operand
op_code  in  4  operation select
out_valid  out  1  result/flags are valid
out_ready  in  1  consumer accepts the result this cycle
result  out  WIDTH  registered result
zero  out  1  result == 0
negative  out  1  result[WIDTH-1]
carry  out  1  carry/borrow/shifted-out bit (per op)
overflow  out  1  signed overflow, or error condition (per op)
busy  out  1  iterative operation in progress

Behaviour:
- Reset is synchronous and active-high: on clk edge with rst=1 go to IDLE.
  - out_valid=0, busy=0, result=0, zero=0, negative=0, carry=0, overflow=0.
  - Internal iteration counter and accumulators are cleared.
  - rst overrides every other input, including in the middle of BUSY; the partial result is discarded and no out_valid is produced.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Back-to-back issue is allowed on the same cycle the result is consumed.
- Accept condition: in_valid & in_ready. A, B and op_code are latched; later input changes are ignored.
- Single-cycle ops go to DONE on the accept edge, so out_valid is high the next cycle (latency 1).
- Iterative ops go to BUSY with busy=1 and count=WIDTH. Exactly WIDTH iteration edges follow, then DONE.
  - out_valid rises WIDTH+1 cycles after accept.
- DONE holds result and flags stable while out_valid=1 & out_ready=0.
- On out_ready=1 in DONE:
  - Go to IDLE, or, if a new op is accepted on the same edge, load it (DONE->DONE or DONE->BUSY).
- in_valid is ignored in BUSY (in_ready=0).
- Op codes 0000-0110 (ADD, SUB, AND, OR, XOR, SHL, SHR) keep the legacy semantics:
  - ADD: carry = bit WIDTH of A+B; overflow = signed overflow.
  - SUB: carry = borrow (A<B unsigned); overflow = signed overflow.
  - AND/OR/XOR: carry=0, overflow=0.
  - SHL: carry=A[WIDTH-1]; overflow = A[WIDTH-1]^A[WIDTH-2].
  - SHR (logical): carry=A[0]; overflow=0.
- 0111 MUL (iterative, unsigned shift-add): result = low WIDTH bits of the 2*WIDTH product. carry = overflow = (high half != 0). This replaces the legacy single-bit check.
- 1000 ASR: result = arithmetic shift right of A by 1 (sign-fill). carry=A[0]; overflow=0.
- 1001 ROL: result = {A[WIDTH-2:0],A[WIDTH-1]}; carry=A[WIDTH-1]; overflow=0.
- 1010 ROR: result = {A[0],A[WIDTH-1:1]}; carry=A[0]; overflow=0.
- 1011 MULH (iterative): result = high WIDTH bits of the unsigned product; carry=0; overflow=0.
- 1100 DIVU (iterative, restoring, MSB first): result = floor(A/B); carry=0.
- 1101 REMU (iterative): result = A mod B; carry=0.
- Divide by zero (B==0, DIVU/REMU):
  - Still takes the full WIDTH iterations.
  - DIVU result = all ones; REMU result = A; overflow=1.
- Codes 1110, 1111: single-cycle; result=0, carry=0, overflow=1 (illegal-op indication); zero=1.
- zero and negative are always derived from the final registered result.
- All arithmetic is unsigned modulo 2^WIDTH, except the signed-overflow flags of ADD/SUB/SHL.

Test Plan:
- WIDTH=8, reset then ADD A=0x7F B=0x01, out_ready=1 -> out_valid 1 cycle after accept; result=0x80, negative=1, overflow=1, carry=0, zero=0.
- MUL A=0x10 B=0x20 -> in_ready=0 and busy=1 for 8 cycles; out_valid at accept+9; result=0x00, zero=1, carry=1, overflow=1. MULH with the same operands -> result=0x02.
- DIVU A=200 B=7 -> result=28. REMU with the same operands -> result=4. DIVU A=0x55 B=0 -> result=0xFF, overflow=1. REMU A=0x55 B=0 -> result=0x55, overflow=1.
- Backpressure: XOR A=0xF0 B=0xFF with out_ready=0 for 5 cycles -> result=0x0F held stable, in_ready=0. Then out_ready=1 together with a new in_valid (ROR A=0x01) -> both transfers on the same edge; next result=0x80, carry=1.
- rst=1 asserted at iteration 4 of a DIVU -> next cycle out_valid=0, busy=0, result=0, all flags 0, in_ready=1; no stale result appears afterwards.
- ASR A=0x81 -> result=0xC0, carry=1. Illegal op 1111 -> result=0, zero=1, overflow=1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked multicycle ALU. Single-cycle ops finish on the accept
// edge. MUL/MULH (shift-add) and DIVU/REMU (restoring) iterate one bit per
// clock and share one pair of working registers.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       op_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SHL  = 4'b0101;
   localparam logic [3:0] OP_SHR  = 4'b0110;
   localparam logic [3:0] OP_MUL  = 4'b0111;
   localparam logic [3:0] OP_ASR  = 4'b1000;
   localparam logic [3:0] OP_ROL  = 4'b1001;
   localparam logic [3:0] OP_ROR  = 4'b1010;
   localparam logic [3:0] OP_MULH = 4'b1011;
   localparam logic [3:0] OP_DIVU = 4'b1100;
   localparam logic [3:0] OP_REMU = 4'b1101;

   localparam int CW = $clog2(WIDTH + 1);

   logic [1:0]       state;
   logic [3:0]       op_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [CW-1:0]    count;

   logic             accept;
   logic             is_iter;

   logic [WIDTH-1:0] sc_result;
   logic             sc_carry;
   logic             sc_overflow;
   logic [WIDTH:0]   add_full;
   logic [WIDTH:0]   sub_full;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_diff;
   logic             rem_ge;
   logic [WIDTH-1:0] iter_hi;
   logic [WIDTH-1:0] iter_lo;

   logic [WIDTH-1:0] fin_result;
   logic             fin_carry;
   logic             fin_overflow;

   assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_BUSY);
   assign is_iter   = (op_code == OP_MUL) | (op_code == OP_MULH) |
                      (op_code == OP_DIVU) | (op_code == OP_REMU);

   // Result and flags of the ops that complete on the accept edge, taken straight from the inputs
   always_comb begin
      add_full    = {1'b0, A} + {1'b0, B};
      sub_full    = {1'b0, A} - {1'b0, B};
      sc_result   = '0;
      sc_carry    = 1'b0;
      sc_overflow = 1'b0;
      case (op_code)
         OP_ADD: begin
            sc_result   = add_full[WIDTH-1:0];
            sc_carry    = add_full[WIDTH];
            sc_overflow = (A[WIDTH-1] == B[WIDTH-1]) & (add_full[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            sc_result   = sub_full[WIDTH-1:0];
            sc_carry    = sub_full[WIDTH];
            sc_overflow = (A[WIDTH-1] != B[WIDTH-1]) & (sub_full[WIDTH-1] != A[WIDTH-1]);
         end
         OP_AND: sc_result = A & B;
         OP_OR:  sc_result = A | B;
         OP_XOR: sc_result = A ^ B;
         OP_SHL: begin
            sc_result   = {A[WIDTH-2:0], 1'b0};
            sc_carry    = A[WIDTH-1];
            sc_overflow = A[WIDTH-1] ^ A[WIDTH-2];
         end
         OP_SHR: begin
            sc_result = {1'b0, A[WIDTH-1:1]};
            sc_carry  = A[0];
         end
         OP_ASR: begin
            sc_result = {A[WIDTH-1], A[WIDTH-1:1]};
            sc_carry  = A[0];
         end
         OP_ROL: begin
            sc_result = {A[WIDTH-2:0], A[WIDTH-1]};
            sc_carry  = A[WIDTH-1];
         end
         OP_ROR: begin
            sc_result = {A[0], A[WIDTH-1:1]};
            sc_carry  = A[0];
         end
         OP_MUL, OP_MULH, OP_DIVU, OP_REMU: begin
            sc_result = '0;
         end
         default: begin
            sc_overflow = 1'b1;
         end
      endcase
   end

   // One iteration step: shift-add multiply ({hi,lo} shifts right) or restoring divide (remainder in hi, quotient shifts into lo)
   always_comb begin
      mul_sum  = {1'b0, hi} + {1'b0, (lo[0] ? b_r : {WIDTH{1'b0}})};
      rem_sh   = {hi, lo[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, b_r};
      rem_ge   = (rem_sh >= {1'b0, b_r});
      if ((op_r == OP_MUL) | (op_r == OP_MULH)) begin
         iter_hi = mul_sum[WIDTH:1];
         iter_lo = {mul_sum[0], lo[WIDTH-1:1]};
      end else begin
         iter_hi = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
         iter_lo = {lo[WIDTH-2:0], rem_ge};
      end
   end

   // Final result of an iterative op, formed from the last iteration step; B==0 divides are forced to their defined values
   always_comb begin
      fin_result   = '0;
      fin_carry    = 1'b0;
      fin_overflow = 1'b0;
      case (op_r)
         OP_MUL: begin
            fin_result   = iter_lo;
            fin_carry    = (iter_hi != '0);
            fin_overflow = (iter_hi != '0);
         end
         OP_MULH: fin_result = iter_hi;
         OP_DIVU: begin
            fin_result   = (b_r == '0) ? {WIDTH{1'b1}} : iter_lo;
            fin_overflow = (b_r == '0);
         end
         OP_REMU: begin
            fin_result   = (b_r == '0) ? a_r : iter_hi;
            fin_overflow = (b_r == '0);
         end
         default: fin_result = '0;
      endcase
   end

   // Handshake FSM plus registered result/flags; reset discards any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         op_r     <= '0;
         a_r      <= '0;
         b_r      <= '0;
         hi       <= '0;
         lo       <= '0;
         count    <= '0;
         result   <= '0;
         zero     <= 1'b0;
         negative <= 1'b0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            S_BUSY: begin
               hi    <= iter_hi;
               lo    <= iter_lo;
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  state    <= S_DONE;
                  result   <= fin_result;
                  zero     <= (fin_result == '0);
                  negative <= fin_result[WIDTH-1];
                  carry    <= fin_carry;
                  overflow <= fin_overflow;
               end
            end
            default: begin
               if (accept) begin
                  op_r <= op_code;
                  a_r  <= A;
                  b_r  <= B;
                  if (is_iter) begin
                     state <= S_BUSY;
                     hi    <= '0;
                     lo    <= A;
                     count <= CW'(WIDTH);
                  end else begin
                     state    <= S_DONE;
                     result   <= sc_result;
                     zero     <= (sc_result == '0);
                     negative <= sc_result[WIDTH-1];
                     carry    <= sc_carry;
                     overflow <= sc_overflow;
                  end
               end else if ((state == S_DONE) & out_ready) begin
                  state <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=8) against an
// arithmetic reference model of the operation set.
module tb_alu_seq;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       op_code;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             negative;
   logic             carry;
   logic             overflow;
   logic             busy;

   int nChecks = 0;
   int nFails  = 0;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .op_code(op_code), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero),
      .negative(negative), .carry(carry), .overflow(overflow), .busy(busy)
   );

   // Free-running clock, 10 time units per period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: expected {result, zero, negative, carry, overflow} from plain integer arithmetic
   function automatic logic [11:0] model(input logic [3:0] op, input int a, input int b);
      int res, c, v, sa, sb, s, p;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      p  = a * b;
      c  = 0;
      v  = 0;
      case (op)
         4'd0: begin res = (a + b) % 256; c = (a + b) / 256; s = sa + sb; v = (s > 127 || s < -128) ? 1 : 0; end
         4'd1: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; s = sa - sb; v = (s > 127 || s < -128) ? 1 : 0; end
         4'd2: res = a & b;
         4'd3: res = a | b;
         4'd4: res = a ^ b;
         4'd5: begin res = (a * 2) % 256; c = a / 128; v = ((a / 128) + (a / 64)) % 2; end
         4'd6: begin res = a / 2; c = a % 2; end
         4'd7: begin res = p % 256; c = (p / 256 != 0) ? 1 : 0; v = c; end
         4'd8: begin res = a / 2 + (a / 128) * 128; c = a % 2; end
         4'd9: begin res = (a * 2) % 256 + a / 128; c = a / 128; end
         4'd10: begin res = a / 2 + (a % 2) * 128; c = a % 2; end
         4'd11: res = p / 256;
         4'd12: begin res = (b == 0) ? 255 : a / b; v = (b == 0) ? 1 : 0; end
         4'd13: begin res = (b == 0) ? a : a % b; v = (b == 0) ? 1 : 0; end
         default: begin res = 0; v = 1; end
      endcase
      return {res[7:0], (res == 0), (res >= 128), c[0], v[0]};
   endfunction

   // Issue one op from IDLE, wait (bounded) for the result, capture it, then consume it
   task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                output int lat, output int busyCycles, output logic [11:0] obs);
      @(negedge clk);
      op_code   = op;
      A         = a;
      B         = b;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid   = 1'b0;
      A          = 8'($urandom);
      B          = 8'($urandom);
      op_code    = 4'($urandom);
      lat        = 1;
      busyCycles = 0;
      while (!out_valid && lat < 40) begin
         if (busy && !in_ready) busyCycles++;
         @(posedge clk);
         #1;
         lat++;
      end
      obs = {result, zero, negative, carry, overflow};
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [12:0] obs;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      obs = {out_valid, busy, result, zero, negative, carry, overflow};
      nChecks++;
      if (obs !== 13'h0) begin
         nFails++;
         $display("[TB] FAIL reset_state got=%h expected=%h", obs, 13'h0);
      end
      nChecks++;
      if (in_ready !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL reset_in_ready got=%b expected=1", in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add();
      int lat, bc;
      logic [11:0] obs;
      applyStimulus(4'd0, 8'h7F, 8'h01, lat, bc, obs);
      nChecks++;
      if (lat !== 1) begin
         nFails++;
         $display("[TB] FAIL add_latency got=%0d expected=1", lat);
      end
      nChecks++;
      if (obs !== {8'h80, 1'b0, 1'b1, 1'b0, 1'b1}) begin
         nFails++;
         $display("[TB] FAIL add_7f_01 got=%h expected=%h", obs, {8'h80, 4'b0101});
      end
   endtask

   task automatic test_mul();
      int lat, bc;
      logic [11:0] obs;
      applyStimulus(4'd7, 8'h10, 8'h20, lat, bc, obs);
      nChecks++;
      if (lat !== 9 || bc !== 8) begin
         nFails++;
         $display("[TB] FAIL mul_timing got lat=%0d busy=%0d expected lat=9 busy=8", lat, bc);
      end
      nChecks++;
      if (obs !== {8'h00, 1'b1, 1'b0, 1'b1, 1'b1}) begin
         nFails++;
         $display("[TB] FAIL mul_10_20 got=%h expected=%h", obs, {8'h00, 4'b1011});
      end
      applyStimulus(4'd11, 8'h10, 8'h20, lat, bc, obs);
      nChecks++;
      if (obs !== {8'h02, 4'b0000}) begin
         nFails++;
         $display("[TB] FAIL mulh_10_20 got=%h expected=%h", obs, {8'h02, 4'b0000});
      end
   endtask

   task automatic test_div();
      int lat, bc;
      logic [11:0] obs;
      applyStimulus(4'd12, 8'd200, 8'd7, lat, bc, obs);
      nChecks++;
      if (obs !== {8'd28, 4'b0000} || lat !== 9) begin
         nFails++;
         $display("[TB] FAIL divu_200_7 got=%h lat=%0d expected=%h lat=9", obs, lat, {8'd28, 4'b0000});
      end
      applyStimulus(4'd13, 8'd200, 8'd7, lat, bc, obs);
      nChecks++;
      if (obs !== {8'd4, 4'b0000}) begin
         nFails++;
         $display("[TB] FAIL remu_200_7 got=%h expected=%h", obs, {8'd4, 4'b0000});
      end
      applyStimulus(4'd12, 8'h55, 8'h00, lat, bc, obs);
      nChecks++;
      if (obs !== {8'hFF, 4'b0101} || lat !== 9) begin
         nFails++;
         $display("[TB] FAIL divu_by_zero got=%h lat=%0d expected=%h lat=9", obs, lat, {8'hFF, 4'b0101});
      end
      applyStimulus(4'd13, 8'h55, 8'h00, lat, bc, obs);
      nChecks++;
      if (obs !== {8'h55, 4'b0001}) begin
         nFails++;
         $display("[TB] FAIL remu_by_zero got=%h expected=%h", obs, {8'h55, 4'b0001});
      end
   endtask

   task automatic test_misc();
      int lat, bc;
      logic [11:0] obs;
      applyStimulus(4'd8, 8'h81, 8'h00, lat, bc, obs);
      nChecks++;
      if (obs !== {8'hC0, 4'b0110}) begin
         nFails++;
         $display("[TB] FAIL asr_81 got=%h expected=%h", obs, {8'hC0, 4'b0110});
      end
      applyStimulus(4'd15, 8'h3C, 8'hA5, lat, bc, obs);
      nChecks++;
      if (obs !== {8'h00, 4'b1001} || lat !== 1) begin
         nFails++;
         $display("[TB] FAIL illegal_op got=%h lat=%0d expected=%h lat=1", obs, lat, {8'h00, 4'b1001});
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      op_code   = 4'd4;
      A         = 8'hF0;
      B         = 8'hFF;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A        = 8'h33;
      B        = 8'h44;
      for (int i = 0; i < 5; i++) begin
         nChecks++;
         if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 8'h0F}) begin
            nFails++;
            $display("[TB] FAIL backpressure_hold cycle=%0d got v=%b r=%b res=%h expected v=1 r=0 res=0f",
                     i, out_valid, in_ready, result);
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op_code   = 4'd10;
      A         = 8'h01;
      B         = 8'($urandom);
      #1;
      nChecks++;
      if (in_ready !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL same_edge_ready got=%b expected=1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      nChecks++;
      if ({out_valid, result, carry} !== {1'b1, 8'h80, 1'b1}) begin
         nFails++;
         $display("[TB] FAIL same_edge_ror got v=%b res=%h c=%b expected v=1 res=80 c=1",
                  out_valid, result, carry);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_busy();
      logic [12:0] obs;
      int seenValid;
      @(negedge clk);
      op_code  = 4'd12;
      A        = 8'd200;
      B        = 8'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      obs = {out_valid, busy, result, zero, negative, carry, overflow};
      nChecks++;
      if (obs !== 13'h0 || in_ready !== 1'b1) begin
         nFails++;
         $display("[TB] FAIL reset_mid_busy got=%h ready=%b expected=0000 ready=1", obs, in_ready);
      end
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      seenValid = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seenValid++;
      end
      out_ready = 1'b0;
      nChecks++;
      if (seenValid !== 0) begin
         nFails++;
         $display("[TB] FAIL no_stale_result got=%0d valid cycles expected=0", seenValid);
      end
   endtask

   task automatic test_random();
      int lat, bc, expLat;
      logic [11:0] obs, exp;
      logic [3:0] op;
      logic [7:0] a, b;
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = 8'($urandom_range(0, 255));
         b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         exp    = model(op, int'(a), int'(b));
         expLat = (op == 4'd7 || op == 4'd11 || op == 4'd12 || op == 4'd13) ? 9 : 1;
         applyStimulus(op, a, b, lat, bc, obs);
         nChecks++;
         if (obs !== exp || lat !== expLat) begin
            nFails++;
            $display("[TB] FAIL random op=%0d a=%h b=%h got=%h lat=%0d expected=%h lat=%0d",
                     op, a, b, obs, lat, exp, expLat);
         end
      end
   endtask

   // Streams ops with out_ready held high so results are consumed while the next op is accepted on the same edge
   task automatic test_back_to_back();
      logic [11:0] expQ[$];
      logic [11:0] obs, exp;
      int issued, cycles;
      logic pending;
      issued  = 0;
      cycles  = 0;
      pending = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      while ((issued < 20 || expQ.size() > 0) && cycles < 400) begin
         if (out_valid) begin
            obs = {result, zero, negative, carry, overflow};
            exp = (expQ.size() > 0) ? expQ.pop_front() : 12'hXXX;
            nChecks++;
            if (obs !== exp) begin
               nFails++;
               $display("[TB] FAIL back_to_back got=%h expected=%h", obs, exp);
            end
         end
         if (!pending && issued < 20) begin
            op_code  = 4'($urandom_range(0, 15));
            A        = 8'($urandom);
            B        = 8'($urandom);
            in_valid = 1'b1;
            pending  = 1'b1;
         end
         #1;
         if (pending && in_ready) begin
            expQ.push_back(model(op_code, int'(A), int'(B)));
            issued++;
            pending = 1'b0;
         end
         @(posedge clk);
         #1;
         if (!pending) in_valid = 1'b0;
         @(negedge clk);
         cycles++;
      end
      nChecks++;
      if (cycles >= 400) begin
         nFails++;
         $display("[TB] FAIL back_to_back_timeout got=%0d cycles expected<400", cycles);
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   // Test sequence
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      op_code   = '0;
      test_reset();
      test_add();
      test_mul();
      test_div();
      test_misc();
      test_backpressure();
      test_reset_mid_busy();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
